instruction_fetch: RTL
======================

# instruction_fetch

Front-end pipeline stage that owns the program counter. It issues instruction-memory requests over a valid/ready channel and buffers in-order responses. It presents one instruction per cycle to instruction decode as `pc_output_valid` / `instruction` / `instruction_pc`, honours decode's stall, and redirects on a resolved branch (`branch_reset`), discarding every wrong-path fetch, including responses still in flight.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC of the first fetch after reset.
- `DEPTH`, default 2: maximum number of fetches outstanding or buffered; legal range 1 to 4.

Ports:
- `clk`  in  1  single clock, all state on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  64  fetch address, equal to `fetch_pc`.
- `imem_rsp_valid`  in  1  response valid. There is no backpressure; responses return in request order, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `stall_in`  in  1  decode stall; hold the output register.
- `branch_reset`  in  1  redirect strobe from EX.
- `branch_target`  in  64  new PC, valid when `branch_reset`=1.
- `pc_output_valid`  out  1  output register holds a live instruction.
- `instruction`  out  32  latched instruction.
- `instruction_pc`  out  64  PC of `instruction`.

## Operation
- **State**
  - `fetch_pc` (64 bits).
  - In-order queue of `DEPTH` entries, each {pc, data, filled}.
  - `drop_count` (0 to `DEPTH`): responses owed to squashed requests.
  - Output register.
- **Occupancy** = queue entries + `drop_count`.
- **Request**
  - `imem_req_valid` = (occupancy < `DEPTH`) and !`branch_reset`.
  - Once asserted, `valid` and `addr` hold until accepted. The only exception is `branch_reset`, which may retract the request.
  - On accept: allocate a tail entry {pc=`fetch_pc`, filled=0}; `fetch_pc` += 4, wrapping mod 2^64.
- **Response**
  - If `drop_count` > 0: decrement it and discard the data.
  - Otherwise: fill the oldest unfilled entry.
  - A response never arrives while occupancy = 0 and `drop_count` = 0; the bench flags this as an error.
- **Output advance, when !`stall_in`**
  - Head filled: load {data, pc} and set `pc_output_valid`=1; pop the head.
  - Head unfilled but a response for the head arrives this cycle: bypass the response directly into the output register and pop.
  - Otherwise: `pc_output_valid`=0, and `instruction` / `instruction_pc` keep their old values.
- **Stall**: when `stall_in`=1, the output register holds. Requests and responses continue until occupancy reaches `DEPTH`.
- **Redirect**: `branch_reset`=1 takes priority over `stall_in` and over every other event in the same cycle.
  - `fetch_pc` <= `branch_target`.
  - `pc_output_valid` <= 0.
  - Every unfilled entry, counting an entry whose response arrives this same cycle as filled, adds 1 to `drop_count`.
  - The queue is emptied.
  - No request is issued this cycle.
- **Reset** (`rst`=0, asynchronous)
  - `fetch_pc` = `RESET_PC`.
  - Queue empty; `drop_count`=0.
  - `pc_output_valid`=0, `instruction`=0, `instruction_pc`=0.
  - `imem_req_valid`=0.
  - Fetching resumes the first cycle after deassertion.
  - A reset during outstanding fetches is legal. The memory is reset by the same signal, so stale responses do not arrive.

## Timing
- First request is valid in the first cycle after reset release.
- With `imem_req_ready`=1 and a 1-cycle memory:
  - Request accepted in cycle N, response in N+1, `pc_output_valid`=1 from cycle N+2.
  - Sustained throughput is 1 instruction per cycle with `DEPTH`≥2.
- Redirect in cycle R:
  - First target request is valid in R+1.
  - With a 1-cycle memory and nothing pending to drop, the first target instruction is output in R+3.
  - Each owed drop delays the target instruction by 1 cycle.
- `pc_output_valid` is 0 in cycle R+1 regardless of `stall_in`.

## Test plan
- **Reset**: `RESET_PC`=64'h1000, ready=1, 1-cycle memory returning PC-derived words. Requests go to 1000, 1004, 1008…; output valid from cycle 2 with `instruction_pc`=1000, then one instruction per cycle.
- **Stall**: hold `stall_in`=1 for 5 cycles while the output shows 1008. Output stays at 1008; at most `DEPTH` further requests are issued. After release, outputs are 100C, 1010 back-to-back with no gap or duplicate.
- **Redirect with in-flight fetches**: 3-cycle memory, 2 requests outstanding, `branch_reset` with target 64'h2000. `drop_count`=2; both stale responses are discarded; the first valid output has `instruction_pc`=2000.
- **Redirect while stalled**: `stall_in`=1 and `branch_reset`=1 in the same cycle. Next cycle `pc_output_valid`=0, and the next request address is 2000.
- **Backpressure**: `imem_req_ready` toggles 1,0,0,1. Address is held stable while ready=0; no address is skipped; outputs are strictly +4 apart.
- **PC wrap**: `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC. Request addresses are FFFF_FFFF_FFFF_FFFC, then 0, 4.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, issues in-order imem fetches, buffers responses, squashes wrong-path fetches on redirect
module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall_in,
   input  logic        branch_reset,
   input  logic [63:0] branch_target,
   output logic        pc_output_valid,
   output logic [31:0] instruction,
   output logic [63:0] instruction_pc
);
   localparam logic [2:0] DEP = 3'(DEPTH);
   logic [63:0] fetch_pc, fetch_n, ipc_n;
   logic [63:0] pc_q [4];
   logic [63:0] pc_n [4];
   logic [31:0] data_q [4];
   logic [31:0] data_n [4];
   logic [31:0] instr_n;
   logic [2:0]  cnt, fill_cnt, drop_cnt, cnt_n, fill_n, drop_n;
   logic        valid_n, accept, rsp_fill, rsp_drop;
   assign rsp_drop       = imem_rsp_valid && drop_cnt != 3'd0;
   assign rsp_fill       = imem_rsp_valid && drop_cnt == 3'd0 && fill_cnt < cnt;
   assign imem_req_valid = rst && (cnt + drop_cnt < DEP) && !branch_reset;
   assign imem_req_addr  = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;
   // Filled entries always form a prefix of the queue, so fill_cnt indexes the oldest unfilled one.
   always_comb begin
      pc_n    = pc_q;
      data_n  = data_q;
      cnt_n   = cnt;
      fill_n  = fill_cnt;
      fetch_n = fetch_pc;
      drop_n  = drop_cnt - {2'b0, rsp_drop};
      valid_n = pc_output_valid;
      instr_n = instruction;
      ipc_n   = instruction_pc;
      if (rsp_fill) begin
         data_n[fill_cnt[1:0]] = imem_rsp_data;
         fill_n = fill_cnt + 3'd1;
      end
      if (branch_reset) begin
         drop_n  = drop_n + (cnt - fill_n);
         cnt_n   = 3'd0;
         fill_n  = 3'd0;
         fetch_n = branch_target;
         valid_n = 1'b0;
      end else begin
         if (accept) begin
            pc_n[cnt[1:0]] = fetch_pc;
            cnt_n   = cnt + 3'd1;
            fetch_n = fetch_pc + 64'd4;
         end
         if (!stall_in) begin
            valid_n = fill_n != 3'd0;
            if (fill_n != 3'd0) begin
               instr_n = data_n[0];
               ipc_n   = pc_n[0];
               for (int i = 0; i < 3; i++) begin
                  pc_n[i]   = pc_n[i+1];
                  data_n[i] = data_n[i+1];
               end
               cnt_n  = cnt_n - 3'd1;
               fill_n = fill_n - 3'd1;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc        <= RESET_PC;
         pc_q            <= '{default: '0};
         data_q          <= '{default: '0};
         cnt             <= 3'd0;
         fill_cnt        <= 3'd0;
         drop_cnt        <= 3'd0;
         pc_output_valid <= 1'b0;
         instruction     <= '0;
         instruction_pc  <= '0;
      end else begin
         fetch_pc        <= fetch_n;
         pc_q            <= pc_n;
         data_q          <= data_n;
         cnt             <= cnt_n;
         fill_cnt        <= fill_n;
         drop_cnt        <= drop_n;
         pc_output_valid <= valid_n;
         instruction     <= instr_n;
         instruction_pc  <= ipc_n;
      end
   end
endmodule
